// File: rtl/mux_select_sequencer_if.sv
// rtl/mux_select_sequencer_if.sv - control and select bundle between bring-up logic and the HEX character mux sequencer
//
// Purpose : groups the sequencer's mode/step/load controls and its select/pulse outputs.
// Modports:
//   master : drives run, dir, step, load, load_sel; observes S0..S2, tick, wrap
//   slave  : the sequencer itself (mux_select_sequencer)
// Signals :
//   run       1 = auto-advance on prescaler tick, 0 = paused
//   dir       0 = forward 0->4, 1 = backward 4->0
//   step      level single-step request, acts on rising edge while paused
//   load      synchronous load of load_sel, highest priority
//   load_sel  3-bit load value, 5..7 load 0
//   S0,S1,S2  registered select code (S2 = MSB)
//   tick      one-cycle pulse on an auto-advance
//   wrap      one-cycle pulse when an advance wraps 4->0 or 0->4

interface mux_select_sequencer_if;
    logic       run;
    logic       dir;
    logic       step;
    logic       load;
    logic [2:0] load_sel;
    logic       S0;
    logic       S1;
    logic       S2;
    logic       tick;
    logic       wrap;

    modport master (
        output run,
        output dir,
        output step,
        output load,
        output load_sel,
        input  S0,
        input  S1,
        input  S2,
        input  tick,
        input  wrap
    );

    modport slave (
        input  run,
        input  dir,
        input  step,
        input  load,
        input  load_sel,
        output S0,
        output S1,
        output S2,
        output tick,
        output wrap
    );
endinterface

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - 0..4 select code generator for the 5-to-1 HEX character mux
//
// Purpose : rotates a 3-bit select through 0..4 at a prescaled rate (RUNNING) or holds it
//           (PAUSED) with single-step and direct-load controls for board bring-up.
// Ports   :
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mux_select_sequencer_if.slave (run, dir, step, load, load_sel in;
//            S0, S1, S2, tick, wrap out, all outputs registered)
// Parameters:
//   TICK_DIV clock cycles per automatic advance (2 .. 2^26)
//   NUM_SEL  number of select codes, fixed at 5

module mux_select_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int NUM_SEL  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mux_select_sequencer_if.slave   bus
);

    localparam int          CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]  SEL_LAST = 3'(NUM_SEL - 1);

    logic [2:0]       sel;
    logic [CNT_W-1:0] pcnt;
    logic             step_q;
    logic             tick_r;
    logic             wrap_r;

    logic             step_edge;
    logic             adv_wraps;
    logic [2:0]       sel_next;
    logic [2:0]       sel_load;

    assign step_edge = bus.step & ~step_q;

    // One position forward or backward, wrapping within 0..SEL_LAST.
    always_comb begin
        sel_next  = sel;
        adv_wraps = 1'b0;
        if (!bus.dir) begin
            if (sel >= SEL_LAST) begin
                sel_next  = 3'd0;
                adv_wraps = 1'b1;
            end else begin
                sel_next  = sel + 3'd1;
            end
        end else begin
            if (sel == 3'd0) begin
                sel_next  = SEL_LAST;
                adv_wraps = 1'b1;
            end else begin
                sel_next  = sel - 3'd1;
            end
        end
    end

    // Out-of-range load values collapse to 0 so sel never leaves 0..4.
    assign sel_load = (bus.load_sel > SEL_LAST) ? 3'd0 : bus.load_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel    <= 3'd0;
            pcnt   <= '0;
            step_q <= 1'b0;
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            step_q <= bus.step;
            if (bus.load) begin
                // Load wins over a coincident tick or step; that advance is dropped.
                sel    <= sel_load;
                pcnt   <= '0;
                tick_r <= 1'b0;
                wrap_r <= 1'b0;
            end else if (bus.run) begin
                if (pcnt == CNT_LAST) begin
                    pcnt   <= '0;
                    sel    <= sel_next;
                    tick_r <= 1'b1;
                    wrap_r <= adv_wraps;
                end else begin
                    pcnt   <= pcnt + CNT_W'(1);
                    tick_r <= 1'b0;
                    wrap_r <= 1'b0;
                end
            end else begin
                // Paused: pcnt holds so the scroll phase resumes where it left off.
                tick_r <= 1'b0;
                if (step_edge) begin
                    sel    <= sel_next;
                    wrap_r <= adv_wraps;
                end else begin
                    wrap_r <= 1'b0;
                end
            end
        end
    end

    assign bus.S0   = sel[0];
    assign bus.S1   = sel[1];
    assign bus.S2   = sel[2];
    assign bus.tick = tick_r;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - directed self-checking bench for mux_select_sequencer

module tb_mux_select_sequencer;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    mux_select_sequencer_if bus ();

    mux_select_sequencer #(
        .TICK_DIV (4),
        .NUM_SEL  (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_sel();
        return int'({bus.S2, bus.S1, bus.S0});
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input int s, input int t, input int w);
        check({tag, ".sel"},  cur_sel(),       s);
        check({tag, ".tick"}, int'(bus.tick),  t);
        check({tag, ".wrap"}, int'(bus.wrap),  w);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        bus.run      = 1'b0;
        bus.dir      = 1'b0;
        bus.step     = 1'b0;
        bus.load     = 1'b0;
        bus.load_sel = 3'd0;

        cycles(2);
        expect_out("reset", 0, 0, 0);
        reset_n = 1'b1;

        // Forward scroll: 0,1,2,3,4,0 every 4 cycles, wrap only on 4->0.
        bus.run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycles(3);
            expect_out($sformatf("fwd_hold%0d", k), k - 1, 0, 0);
            cycles(1);
            expect_out($sformatf("fwd_adv%0d", k), k % 5, 1, (k == 5) ? 1 : 0);
        end

        // Backward from 0: 4 (wrap), 3, 2, 1, 0.
        bus.dir = 1'b1;
        cycles(4);
        expect_out("bwd_first", 4, 1, 1);
        for (int k = 3; k >= 0; k--) begin
            cycles(4);
            expect_out($sformatf("bwd_adv%0d", k), k, 1, 0);
        end

        // Paused stepping: held-high step counts once, two pulses add two more.
        bus.run  = 1'b0;
        bus.dir  = 1'b0;
        bus.step = 1'b1;
        cycles(1);
        expect_out("step_first", 1, 0, 0);
        cycles(9);
        expect_out("step_held", 1, 0, 0);
        bus.step = 1'b0;
        cycles(1);
        bus.step = 1'b1;
        cycles(1);
        expect_out("step_p1", 2, 0, 0);
        bus.step = 1'b0;
        cycles(1);
        bus.step = 1'b1;
        cycles(1);
        bus.step = 1'b0;
        expect_out("step_p2", 3, 0, 0);

        // Step edge ignored while running; pcnt was 0 so advance after 4 cycles.
        bus.run  = 1'b1;
        bus.step = 1'b1;
        cycles(1);
        expect_out("step_run_ignored", 3, 0, 0);
        bus.step = 1'b0;
        cycles(3);
        expect_out("run_after_step", 4, 1, 0);

        // Pause at pcnt=2 for 20 cycles, resume: advance 2 cycles later.
        cycles(2);
        bus.run = 1'b0;
        cycles(20);
        expect_out("pause_hold", 4, 0, 0);
        bus.run = 1'b1;
        cycles(1);
        expect_out("resume_1", 4, 0, 0);
        cycles(1);
        expect_out("resume_2", 0, 1, 1);

        // Load coincident with a tick edge wins; out-of-range load gives 0.
        cycles(3);
        bus.load     = 1'b1;
        bus.load_sel = 3'd3;
        cycles(1);
        expect_out("load3", 3, 0, 0);
        bus.load_sel = 3'd6;
        cycles(1);
        expect_out("load6", 0, 0, 0);
        bus.load = 1'b0;
        cycles(3);
        expect_out("post_load_hold", 0, 0, 0);
        cycles(1);
        expect_out("post_load_adv", 1, 1, 0);

        // Asynchronous reset between edges, mid-count with sel=2.
        cycles(4);
        expect_out("pre_rst", 2, 1, 0);
        cycles(2);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(3);
        expect_out("rst_release_hold", 0, 0, 0);
        cycles(1);
        expect_out("rst_release_adv", 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
